// File: rtl/ws2812b_pixel_decoder_if.sv
// WS2812B decoder bus: raw data line and target select in, pixel/frame
// results and error strobes out.
interface ws2812b_pixel_decoder_if #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int IDX_W          = 8
);
    logic                      din;
    logic [IDX_W-1:0]          target_idx;
    logic                      pixel_valid;
    logic [BITS_PER_PIXEL-1:0] pixel_data;
    logic [IDX_W-1:0]          pixel_idx;
    logic [BITS_PER_PIXEL-1:0] captured;
    logic                      frame_done;
    logic [IDX_W-1:0]          frame_pixels;
    logic                      err_glitch;
    logic                      err_long;

    // Stimulus / host side
    modport master (
        output din, target_idx,
        input  pixel_valid, pixel_data, pixel_idx, captured,
        input  frame_done, frame_pixels, err_glitch, err_long
    );

    // Decoder side
    modport slave (
        input  din, target_idx,
        output pixel_valid, pixel_data, pixel_idx, captured,
        output frame_done, frame_pixels, err_glitch, err_long
    );
endinterface

// File: rtl/ws2812b_pixel_decoder.sv
// WS2812B receiver: measures DIN high pulses, rejects glitches and over-long
// highs, assembles MSB-first pixel words, tracks the pixel index within a
// frame, detects the latch gap and captures one selected pixel.
module ws2812b_pixel_decoder #(
    parameter int CLK_HZ           = 64000000,
    parameter int THRESHOLD_CYCLES = 38,
    parameter int MIN_HIGH_CYCLES  = 8,
    parameter int MAX_HIGH_CYCLES  = 96,
    parameter int RESET_CYCLES     = 3200,
    parameter int BITS_PER_PIXEL   = 24,
    parameter int IDX_W            = 8,
    parameter int CNT_W            = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ws2812b_pixel_decoder_if.slave  bus
);

    localparam int BCW = $clog2(BITS_PER_PIXEL + 1);

    localparam logic [CNT_W-1:0] L_THRESH   = CNT_W'(THRESHOLD_CYCLES);
    localparam logic [CNT_W-1:0] L_MIN      = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] L_MAX      = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] L_RESET    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] L_RESET_M1 = CNT_W'(RESET_CYCLES - 1);
    localparam logic [BCW-1:0]   L_BPP      = BCW'(BITS_PER_PIXEL);

    // Counters must be able to hold the latch gap; the clock must be real.
    if (RESET_CYCLES >= (2 ** CNT_W) || CLK_HZ <= 0) begin : g_param_check
        $error("ws2812b_pixel_decoder: CNT_W too small for RESET_CYCLES or bad CLK_HZ");
    end

    typedef enum logic [1:0] {
        S_SYNC,
        S_LOW,
        S_GAP,
        S_HIGH
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic                      r_sync1;
    logic                      r_sync2;
    logic [1:0]                r_warm;
    logic                      w_din_s;

    logic [CNT_W-1:0]          r_hcnt;
    logic [CNT_W-1:0]          r_lcnt;
    logic [BCW-1:0]            r_bit_cnt;
    logic [BCW-1:0]            w_bit_cnt_inc;
    logic [BITS_PER_PIXEL-1:0] r_shift;
    logic [BITS_PER_PIXEL-1:0] w_word;
    logic [IDX_W-1:0]          r_idx;

    logic                      w_rise;
    logic                      w_fall;
    logic                      w_gap_hit;
    logic                      w_is_glitch;
    logic                      w_is_long;
    logic                      w_bit;

    logic                      r_pixel_valid;
    logic [BITS_PER_PIXEL-1:0] r_pixel_data;
    logic [IDX_W-1:0]          r_pixel_idx;
    logic [BITS_PER_PIXEL-1:0] r_captured;
    logic                      r_frame_done;
    logic [IDX_W-1:0]          r_frame_pixels;
    logic                      r_err_glitch;
    logic                      r_err_long;

    // Two-flop synchronizer for DIN plus a warm-up flag that marks when the
    // synchronized value is genuine rather than the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_warm  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the chain really delays by one clock per stage.
            r_sync1 <= bus.din;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    assign w_din_s = r_sync2;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and edge/gap event decode.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_gap_hit    = 1'b0;
        case (r_state)
            S_SYNC: begin
                // Only leave once the synchronizer holds a real low, so a line
                // that is high at reset release never yields a partial bit.
                if (r_warm[1] && !w_din_s) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (w_din_s) begin
                    w_state_next = S_HIGH;
                    w_rise       = 1'b1;
                end else if (r_lcnt == L_RESET_M1) begin
                    w_state_next = S_GAP;
                    w_gap_hit    = 1'b1;
                end
            end
            S_GAP: begin
                if (w_din_s) begin
                    w_state_next = S_HIGH;
                    w_rise       = 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_din_s) begin
                    w_state_next = S_LOW;
                    w_fall       = 1'b1;
                end
            end
            default: w_state_next = S_SYNC;
        endcase
    end

    // Pulse classification of the high width measured so far.
    assign w_is_glitch   = (r_hcnt < L_MIN);
    assign w_is_long     = (r_hcnt > L_MAX);
    assign w_bit         = (r_hcnt > L_THRESH);
    assign w_word        = {r_shift[BITS_PER_PIXEL-2:0], w_bit};
    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;

    // High and low width counters, both saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_lcnt <= '0;
        end else begin
            if (w_rise) begin
                r_hcnt <= CNT_W'(1);
                r_lcnt <= '0;
            end else if (r_state == S_HIGH && w_din_s && r_hcnt != '1) begin
                r_hcnt <= r_hcnt + 1'b1;
            end else if (r_state == S_SYNC) begin
                r_lcnt <= '0;
            end else if (r_state == S_LOW && r_lcnt != L_RESET) begin
                r_lcnt <= r_lcnt + 1'b1;
            end
        end
    end

    // Bit assembly, pixel completion, end-of-frame bookkeeping and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is a plain flop vector, not a RAM, so it
            // is reset like any other state and never exposes stale bits.
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_idx          <= '0;
            r_pixel_valid  <= 1'b0;
            r_pixel_data   <= '0;
            r_pixel_idx    <= '0;
            r_captured     <= '0;
            r_frame_done   <= 1'b0;
            r_frame_pixels <= '0;
            r_err_glitch   <= 1'b0;
            r_err_long     <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_glitch  <= 1'b0;
            r_err_long    <= 1'b0;

            if (w_gap_hit) begin
                // Latch gap: publish the pixel count, drop any partial pixel.
                r_frame_done   <= 1'b1;
                r_frame_pixels <= r_idx;
                r_idx          <= '0;
                r_bit_cnt      <= '0;
                r_shift        <= '0;
            end else if (w_fall) begin
                if (w_is_glitch) begin
                    // Too short to be a bit: ignore it, keep the partial pixel.
                    r_err_glitch <= 1'b1;
                end else if (w_is_long) begin
                    // Lost framing inside a pixel: resync on the next bit.
                    r_err_long <= 1'b1;
                    r_shift    <= '0;
                    r_bit_cnt  <= '0;
                end else if (w_bit_cnt_inc == L_BPP) begin
                    r_pixel_valid <= 1'b1;
                    r_pixel_data  <= w_word;
                    r_pixel_idx   <= r_idx;
                    if (r_idx == bus.target_idx) begin
                        r_captured <= w_word;
                    end
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                    if (r_idx != '1) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    r_shift   <= w_word;
                    r_bit_cnt <= w_bit_cnt_inc;
                end
            end
        end
    end

    assign bus.pixel_valid  = r_pixel_valid;
    assign bus.pixel_data   = r_pixel_data;
    assign bus.pixel_idx    = r_pixel_idx;
    assign bus.captured     = r_captured;
    assign bus.frame_done   = r_frame_done;
    assign bus.frame_pixels = r_frame_pixels;
    assign bus.err_glitch   = r_err_glitch;
    assign bus.err_long     = r_err_long;

endmodule
